// File: rtl/cnn_pkg.sv
// Shared defaults, score type and reader state encoding for the CNN result path.
package cnn_pkg;

   localparam int unsigned CNN_NUM_CLASSES = 10;
   localparam int unsigned CNN_SCORE_W     = 32;
   localparam int unsigned CNN_IDX_W       = 4;

   typedef logic signed [CNN_SCORE_W-1:0] score_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      STREAM = 2'd2
   } reader_state_t;

endpackage

// File: rtl/cnn_score_cmp.sv
// Signed strict greater-than used by the argmax scan; equal scores never win.
module cnn_score_cmp #(
   parameter int unsigned SCORE_W = 32
) (
   input  logic signed [SCORE_W-1:0] a_i,
   input  logic signed [SCORE_W-1:0] b_i,
   output logic                      gt_o
);

   always_comb begin
      gt_o = (a_i > b_i);
   end

endmodule

// File: rtl/cnn_result_reader.sv
// Snapshots classifier scores on done_i, optionally scans for the argmax
// (macro CNN_RESULT_ARGMAX_EN), then streams the scores over valid/ready.
module cnn_result_reader
   import cnn_pkg::*;
#(
   parameter int unsigned NUM_CLASSES = CNN_NUM_CLASSES,
   parameter int unsigned SCORE_W     = CNN_SCORE_W,
   parameter int unsigned IDX_W       = CNN_IDX_W
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           done_i,
   input  logic [NUM_CLASSES*SCORE_W-1:0] scores_i,
   output logic                           busy_o,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [SCORE_W-1:0]             out_data_o,
   output logic [IDX_W-1:0]               out_idx_o,
   output logic                           out_last_o,
   output logic                           class_valid_o,
   output logic [IDX_W-1:0]               class_idx_o,
   output logic [SCORE_W-1:0]             class_score_o,
   output logic                           overrun_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   reader_state_t             state_q, state_d;
   logic [IDX_W-1:0]          ptr_q, ptr_d;
   logic signed [SCORE_W-1:0] scores_q [NUM_CLASSES];
   logic signed [SCORE_W-1:0] scores_d [NUM_CLASSES];
   logic                      overrun_q, overrun_d;
   logic signed [SCORE_W-1:0] cur_score;

   assign cur_score = scores_q[ptr_q];

`ifdef CNN_RESULT_ARGMAX_EN
   logic                      class_valid_q, class_valid_d;
   logic [IDX_W-1:0]          best_idx_q, best_idx_d;
   logic signed [SCORE_W-1:0] best_score_q, best_score_d;
   logic                      score_gt;

   cnn_score_cmp #(.SCORE_W(SCORE_W)) u_cmp (
      .a_i  (cur_score),
      .b_i  (best_score_q),
      .gt_o (score_gt)
   );
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      scores_d  = scores_q;
      overrun_d = overrun_q;
`ifdef CNN_RESULT_ARGMAX_EN
      class_valid_d = class_valid_q;
      best_idx_d    = best_idx_q;
      best_score_d  = best_score_q;
`endif

      // Any done_i outside IDLE is dropped, including the final-handshake cycle.
      if (done_i && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (done_i) begin
               for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                  scores_d[k] = scores_i[k*SCORE_W +: SCORE_W];
               end
`ifdef CNN_RESULT_ARGMAX_EN
               class_valid_d = 1'b0;
               best_idx_d    = '0;
               best_score_d  = scores_i[0 +: SCORE_W];
               ptr_d         = IDX_W'(1);
               state_d       = SCAN;
`else
               ptr_d         = '0;
               state_d       = STREAM;
`endif
            end
         end
`ifdef CNN_RESULT_ARGMAX_EN
         SCAN: begin
            if (score_gt) begin
               best_idx_d   = ptr_q;
               best_score_d = cur_score;
            end
            if (ptr_q == LAST_IDX) begin
               class_valid_d = 1'b1;
               ptr_d         = '0;
               state_d       = STREAM;
            end else begin
               ptr_d = ptr_q + IDX_W'(1);
            end
         end
`endif
         STREAM: begin
            if (out_ready_i) begin
               if (ptr_q == LAST_IDX) begin
                  ptr_d   = '0;
                  state_d = IDLE;
               end else begin
                  ptr_d = ptr_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         overrun_q <= 1'b0;
         for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            scores_q[k] <= '0;
         end
`ifdef CNN_RESULT_ARGMAX_EN
         class_valid_q <= 1'b0;
         best_idx_q    <= '0;
         best_score_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         overrun_q <= overrun_d;
         for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            scores_q[k] <= scores_d[k];
         end
`ifdef CNN_RESULT_ARGMAX_EN
         class_valid_q <= class_valid_d;
         best_idx_q    <= best_idx_d;
         best_score_q  <= best_score_d;
`endif
      end
   end

   // Beat outputs are forced to zero outside STREAM so IDLE reads all-zero.
   assign busy_o      = (state_q != IDLE);
   assign out_valid_o = (state_q == STREAM);
   assign out_data_o  = out_valid_o ? cur_score : '0;
   assign out_idx_o   = out_valid_o ? ptr_q : '0;
   assign out_last_o  = out_valid_o && (ptr_q == LAST_IDX);
   assign overrun_o   = overrun_q;

`ifdef CNN_RESULT_ARGMAX_EN
   assign class_valid_o = class_valid_q;
   assign class_idx_o   = best_idx_q;
   assign class_score_o = best_score_q;
`else
   assign class_valid_o = 1'b0;
   assign class_idx_o   = '0;
   assign class_score_o = '0;
`endif

endmodule

// File: tb/tb_cnn_result_reader.sv
// Self-checking bench for cnn_result_reader: behavioural model plus literal
// expectations; adapts to builds with or without CNN_RESULT_ARGMAX_EN.
module tb_cnn_result_reader;

   localparam int NC = 10;
   localparam int SW = 32;
   localparam int IW = 4;
`ifdef CNN_RESULT_ARGMAX_EN
   localparam bit ARGMAX = 1'b1;
   localparam int LAT    = NC;
`else
   localparam bit ARGMAX = 1'b0;
   localparam int LAT    = 1;
`endif

   logic              clk;
   logic              reset;
   logic              done_i;
   logic [NC*SW-1:0]  scores_i;
   logic              busy_o;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [SW-1:0]     out_data_o;
   logic [IW-1:0]     out_idx_o;
   logic              out_last_o;
   logic              class_valid_o;
   logic [IW-1:0]     class_idx_o;
   logic [SW-1:0]     class_score_o;
   logic              overrun_o;

   cnn_result_reader #(.NUM_CLASSES(NC), .SCORE_W(SW), .IDX_W(IW)) dut (
      .clk           (clk),
      .reset         (reset),
      .done_i        (done_i),
      .scores_i      (scores_i),
      .busy_o        (busy_o),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_data_o    (out_data_o),
      .out_idx_o     (out_idx_o),
      .out_last_o    (out_last_o),
      .class_valid_o (class_valid_o),
      .class_idx_o   (class_idx_o),
      .class_score_o (class_score_o),
      .overrun_o     (overrun_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a snapshot, a scan countdown and a beat counter.
   logic [SW-1:0] m_snap [NC];
   bit            m_live = 1'b0;
   bit            m_busy;
   int            m_scan_left;
   int            m_beat;
   bit            m_cls_valid;
   int            m_cls_idx;
   logic [SW-1:0] m_cls_score;
   bit            m_overrun;

   always @(posedge clk) begin
      if (reset) begin
         m_live      = 1'b1;
         m_busy      = 1'b0;
         m_scan_left = 0;
         m_beat      = 0;
         m_cls_valid = 1'b0;
         m_cls_idx   = 0;
         m_cls_score = '0;
         m_overrun   = 1'b0;
      end else if (m_live) begin
         if (m_busy && done_i) m_overrun = 1'b1;
         if (!m_busy) begin
            if (done_i) begin
               for (int i = 0; i < NC; i++) m_snap[i] = scores_i[i*SW +: SW];
               m_busy      = 1'b1;
               m_beat      = 0;
               m_scan_left = LAT - 1;
               m_cls_valid = 1'b0;
            end
         end else if (m_scan_left > 0) begin
            m_scan_left--;
            if (m_scan_left == 0 && ARGMAX) begin
               int best;
               best = 0;
               for (int i = 1; i < NC; i++)
                  if ($signed(m_snap[i]) > $signed(m_snap[best])) best = i;
               m_cls_idx   = best;
               m_cls_score = m_snap[best];
               m_cls_valid = 1'b1;
            end
         end else if (out_ready_i) begin
            if (m_beat == NC - 1) m_busy = 1'b0;
            else m_beat++;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         bit vld;
         vld = m_busy && (m_scan_left == 0);
         check("busy", 64'(busy_o), 64'(m_busy));
         check("valid", 64'(out_valid_o), 64'(vld));
         check("data", 64'(out_data_o), vld ? 64'(m_snap[m_beat]) : 64'd0);
         check("idx", 64'(out_idx_o), vld ? 64'(m_beat) : 64'd0);
         check("last", 64'(out_last_o), 64'(vld && (m_beat == NC - 1)));
         check("class_valid", 64'(class_valid_o), 64'(m_cls_valid));
         check("class_idx", 64'(class_idx_o), 64'(m_cls_idx));
         check("class_score", 64'(class_score_o), 64'(m_cls_score));
         check("overrun", 64'(overrun_o), 64'(m_overrun));
      end
   end

   logic [SW-1:0] stim [NC];
   int fv, fc, idle_at, hs;
   bit aborted;

   // Pulse done_i with stim[], then run until idle. inject_at: beat index at
   // which a second done_i is pulsed; abort_at: beat index at which reset rises.
   task automatic do_run(input int mode, input int inject_at, input int abort_at);
      for (int i = 0; i < NC; i++) scores_i[i*SW +: SW] = stim[i];
      done_i = 1'b1;
      out_ready_i = 1'b1;
      @(negedge clk);
      fv = -1; fc = -1; idle_at = -1; hs = 0; aborted = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         for (int i = 0; i < NC; i++) scores_i[i*SW +: SW] = $urandom();
         done_i = 1'b0;
         if (fv < 0 && out_valid_o) fv = k;
         if (fc < 0 && class_valid_o) fc = k;
         if (!busy_o) begin
            idle_at = k;
            break;
         end
         if (abort_at >= 0 && out_valid_o && int'(out_idx_o) == abort_at) begin
            reset = 1'b1;
            aborted = 1'b1;
            break;
         end
         if (inject_at >= 0 && out_valid_o && int'(out_idx_o) == inject_at) done_i = 1'b1;
         case (mode)
            0: out_ready_i = 1'b1;
            1: out_ready_i = ((k - 1) % 3 == 0);
            default: out_ready_i = 1'($urandom_range(0, 1));
         endcase
         if (out_valid_o && out_ready_i) hs++;
         @(negedge clk);
      end
      done_i = 1'b0;
      if (!aborted && idle_at < 0) check("idle_timeout", 64'(busy_o), 64'd0);
   endtask

   task automatic rand_stim();
      for (int i = 0; i < NC; i++)
         stim[i] = ($urandom_range(0, 1) != 0) ? (32'($urandom_range(0, 6)) - 32'd3) : 32'($urandom());
   endtask

   initial begin
      reset = 1'b1;
      done_i = 1'b0;
      scores_i = '0;
      out_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_valid", 64'(out_valid_o), 64'd0);
      check("rst_overrun", 64'(overrun_o), 64'd0);
      check("rst_class_valid", 64'(class_valid_o), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      stim = '{32'd5, -32'sd3, 32'd12, 32'd7, 32'd12, 32'd0, -32'sd100, 32'd1, 32'd2, 32'd3};
      do_run(0, -1, -1);
      check("t1_first_valid", 64'(fv), 64'(LAT));
      check("t1_idle_at", 64'(idle_at), 64'(LAT + NC));
      check("t1_handshakes", 64'(hs), 64'(NC));
`ifdef CNN_RESULT_ARGMAX_EN
      check("t1_class_valid_at", 64'(fc), 64'd10);
      check("t1_class_idx", 64'(class_idx_o), 64'd2);
      check("t1_class_score", 64'(class_score_o), 64'd12);
`else
      check("t1_class_idx_tied", 64'(class_idx_o), 64'd0);
      check("t1_class_score_tied", 64'(class_score_o), 64'd0);
`endif

      for (int i = 0; i < NC; i++) stim[i] = 32'hFFFF_FFFF;
      do_run(0, -1, -1);
`ifdef CNN_RESULT_ARGMAX_EN
      check("t2_class_idx", 64'(class_idx_o), 64'd0);
      check("t2_class_score", 64'(class_score_o), 64'hFFFF_FFFF);
`endif

      for (int i = 0; i < NC; i++) stim[i] = 32'h8000_0001;
      stim[0] = -32'sd5;
      stim[2] = 32'd7;
      stim[3] = 32'h8000_0000;
      do_run(0, -1, -1);
`ifdef CNN_RESULT_ARGMAX_EN
      check("t3_class_idx_signed", 64'(class_idx_o), 64'd2);
`endif

      rand_stim();
      do_run(1, -1, -1);
      check("t4_handshakes", 64'(hs), 64'(NC));

      rand_stim();
      do_run(0, 3, -1);
      check("t5_handshakes", 64'(hs), 64'(NC));
      check("t5_overrun", 64'(overrun_o), 64'd1);
      repeat (3) @(negedge clk);
      check("t5_overrun_sticky", 64'(overrun_o), 64'd1);

      rand_stim();
      do_run(0, -1, 4);
      check("t6_aborted", 64'(aborted), 64'd1);
      @(negedge clk);
      check("t6_busy", 64'(busy_o), 64'd0);
      check("t6_valid", 64'(out_valid_o), 64'd0);
      check("t6_data", 64'(out_data_o), 64'd0);
      check("t6_overrun", 64'(overrun_o), 64'd0);
      check("t6_class_valid", 64'(class_valid_o), 64'd0);
      reset = 1'b0;
      rand_stim();
      do_run(0, -1, -1);
      check("t6_handshakes", 64'(hs), 64'(NC));

      rand_stim();
      do_run(0, NC - 1, -1);
      check("t7_overrun_last", 64'(overrun_o), 64'd1);
      @(negedge clk);
      check("t7_no_restart", 64'(busy_o), 64'd0);

      for (int r = 0; r < 8; r++) begin
         rand_stim();
         do_run(2, (r % 2 == 0) ? -1 : int'($urandom_range(0, NC - 1)), -1);
         check("rand_handshakes", 64'(hs), 64'(NC));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
